tiger_dmem_port: RTL and testbench
==================================

# tiger_dmem_port

Data-memory port for the Tiger pipeline: accepts one load/store request per transaction from the memory stage, using the size, left/right and zero-extend controls produced by instruction decode. It runs the transfer on an Avalon-MM master with wait-states and read latency, and returns an aligned, sign- or zero-extended result, merged for LWL/LWR. It sits between the memory stage and the data-side bus interconnect. Memory is little-endian.

## Interface
- ADDR_WIDTH, 32, byte-address width of req_addr and avm_address

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  port idle, can accept a request
- req_read  in  1  load (LB/LH/LW/LBU/LHU/LWL/LWR)
- req_write  in  1  store (SB/SH/SW)
- req_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved (error)
- req_lr  in  2  00 none, 10 left (LWL), 01 right (LWR), 11 reserved (error)
- req_zerox  in  1  zero-extend byte/halfword loads
- req_addr  in  ADDR_WIDTH  byte address (base + immediate)
- req_wdata  in  32  store data, right-justified
- req_rtold  in  32  current rt value, merge source for LWL/LWR
- resp_valid  out  1  one-cycle result/completion pulse
- resp_rdata  out  32  load result; 0 for stores
- resp_err  out  1  misaligned or illegal request, valid with resp_valid
- avm_address  out  ADDR_WIDTH  word-aligned address, bits [1:0] always 0
- avm_read, avm_write  out  1  bus commands
- avm_byteenable  out  4  byte lanes
- avm_writedata  out  32  lane-replicated store data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data strobe

## Operation
- States:
  - IDLE: req_ready=1.
  - BUS: command held while avm_waitrequest=1.
  - RDWAIT: waiting for avm_readdatavalid.
  - RESP: resp_valid=1 for one cycle.
  - ERR: resp_valid=1 and resp_err=1 for one cycle.
- Accept: on req_valid && req_ready, all req_* are captured into registers. req_* are don't-care afterwards.
- Illegal request, goes to ERR with no bus access:
  - req_read and req_write both set, or both clear.
  - req_size=11 or req_lr=11.
  - req_lr≠00 together with req_write.
  - Misalignment: halfword with addr[0]=1, or word with no L/R and addr[1:0]≠0. Subject to Configuration.
- Byte enables, with k = addr[1:0]:
  - Byte: 1<<k.
  - Halfword: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Word: 1111.
  - LWL: bytes 0..k.
  - LWR: bytes k..3.
- Store data: byte replicated to all 4 lanes; halfword replicated to both halves.
- Load extraction:
  - Selected byte or halfword is shifted down.
  - Sign-extended unless req_zerox.
- LWL: resp_rdata = (mem << 8·(3−k)) | (rtold & ((1<<8·(3−k))−1)).
- LWR: resp_rdata = (mem >> 8·k) | (rtold & ~(32'hFFFFFFFF >> 8·k)).
- Transitions:
  - BUS to RESP (write) or RDWAIT (read) on the first cycle with avm_waitrequest=0.
  - RDWAIT to RESP on avm_readdatavalid. Data is registered that cycle.
  - If avm_readdatavalid arrives in the same cycle the command is accepted, the FSM goes directly to RESP.
  - RESP and ERR return to IDLE.
- avm_readdatavalid is ignored outside BUS and RDWAIT.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE, req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - avm_read=0, avm_write=0, avm_byteenable=0, avm_address=0, avm_writedata=0.
- Accept at edge 0:
  - avm command visible in cycle 1.
  - Zero wait states: write resp_valid in cycle 2.
  - Read with 1-cycle latency (readdatavalid in cycle 2): resp_valid in cycle 3.
- Error path: resp_valid and resp_err in cycle 1.
- Each extra waitrequest or latency cycle adds exactly one cycle.
- req_ready is low from cycle 1 until the cycle after the RESP/ERR pulse. One transaction is outstanding at most.
- avm_* outputs stay stable while avm_waitrequest=1.
- Reset mid-transaction:
  - Next edge drops avm_read/avm_write and returns to IDLE.
  - No resp_valid is generated.
  - A late readdatavalid is discarded.

## Configuration
- TIGER_DMEM_MISALIGN_TRAP_EN defined: misaligned word/halfword requests take the ERR path.
- Not defined:
  - Misalignment is not checked.
  - Address bits below the access size are treated as 0.
  - The access proceeds normally.
  - resp_err asserts only for illegal control encodings.

## Test plan
- SB of 0x000000A5 at 0x1003, zero wait -> avm_byteenable=1000, avm_writedata=0xA5A5A5A5, avm_address=0x1000, resp_valid in cycle 2, resp_rdata=0.
- LH at 0x2002 with avm_readdata=0x80FF1234, 2 wait states and latency 3 -> resp_rdata=0xFFFF80FF at cycle 1+2+3+1. Same with req_zerox=1 -> 0x000080FF.
- LWL at k=1, mem=0xAABBCCDD, rtold=0x11223344 -> 0xCCDD3344. LWR at k=1, same inputs -> 0x11AABBCC.
- LW at 0x3002 -> with TIGER_DMEM_MISALIGN_TRAP_EN defined: resp_err=1 in cycle 1, no avm_read. Without it: read at 0x3000, resp_err=0.
- Reset asserted while in RDWAIT, readdatavalid arriving after reset -> no resp_valid, req_ready=1, all avm outputs 0.
- req_read=req_write=1 -> ERR pulse, no bus activity. Then back-to-back LW requests are accepted only when req_ready=1.

Source files
------------

// File: rtl/tiger_dmem_port.sv
// Tiger data-memory port: one load/store per transaction on an Avalon-MM master,
// with LWL/LWR merge and sign/zero extension. Optional macro: TIGER_DMEM_MISALIGN_TRAP_EN.
module tiger_dmem_port #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic [1:0]            req_lr,
   input  logic                  req_zerox,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [31:0]           req_rtold,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [3:0]            avm_byteenable,
   output logic [31:0]           avm_writedata,
   input  logic [31:0]           avm_readdata,
   input  logic                  avm_waitrequest,
   input  logic                  avm_readdatavalid
);

   typedef enum logic [2:0] {IDLE, BUS, RDWAIT, RESP, ERR} state_t;

   state_t      state, state_nxt;
   logic        accept, illegal, misalign, rd_cap;
   logic [1:0]  k_eff;
   logic        read_r, zerox_r;
   logic [1:0]  size_r, lr_r, k_r;
   logic [31:0] rtold_r;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lr,
                                          input logic [1:0] k);
      logic [3:0] be;
      be = 4'b1111;
      if (lr == 2'b10) begin
         case (k)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0011;
            2'd2:    be = 4'b0111;
            default: be = 4'b1111;
         endcase
      end else if (lr == 2'b01) begin
         be = 4'b1111 << k;
      end else if (size == 2'b10) begin
         be = 4'b0001 << k;
      end else if (size == 2'b01) begin
         be = k[1] ? 4'b1100 : 4'b0011;
      end
      return be;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         2'b10:   d = {4{wdata[7:0]}};
         2'b01:   d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   // LWL/LWR: shift amounts are 8*(3-k) and 8*k; for a 2-bit k, 3-k is simply ~k.
   function automatic logic [31:0] load_result(input logic [31:0] mem, input logic [1:0] size,
                                               input logic [1:0] lr, input logic [1:0] k,
                                               input logic zx, input logic [31:0] rtold);
      logic [4:0]  shl, shr;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      shl = {~k, 3'b000};
      shr = {k, 3'b000};
      b   = 8'(mem >> shr);
      h   = k[1] ? mem[31:16] : mem[15:0];
      r   = mem;
      if (lr == 2'b10)
         r = (mem << shl) | (rtold & ~(32'hFFFF_FFFF << shl));
      else if (lr == 2'b01)
         r = (mem >> shr) | (rtold & ~(32'hFFFF_FFFF >> shr));
      else if (size == 2'b10)
         r = zx ? {24'h0, b} : {{24{b[7]}}, b};
      else if (size == 2'b01)
         r = zx ? {16'h0, h} : {{16{h[15]}}, h};
      return r;
   endfunction

   always_comb begin
      accept  = (state == IDLE) && req_valid;
      illegal = (req_read == req_write) || (req_size == 2'b11) || (req_lr == 2'b11) ||
                ((req_lr != 2'b00) && req_write);
`ifdef TIGER_DMEM_MISALIGN_TRAP_EN
      misalign = (req_lr == 2'b00) &&
                 (((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)));
`else
      misalign = 1'b0;
`endif
      // Offset bits below the access size are ignored when misalignment is not trapped.
      k_eff = req_addr[1:0];
      if (req_lr == 2'b00 && req_size == 2'b01)
         k_eff = {req_addr[1], 1'b0};
      else if (req_lr == 2'b00 && req_size == 2'b00)
         k_eff = 2'b00;
      rd_cap = read_r && avm_readdatavalid &&
               (((state == BUS) && !avm_waitrequest) || (state == RDWAIT));
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = (illegal || misalign) ? ERR : BUS;
         BUS:     if (!avm_waitrequest)
                     state_nxt = (!read_r || avm_readdatavalid) ? RESP : RDWAIT;
         RDWAIT:  if (avm_readdatavalid) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         read_r  <= req_read;
         zerox_r <= req_zerox;
         size_r  <= req_size;
         lr_r    <= req_lr;
         k_r     <= k_eff;
         rtold_r <= req_rtold;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_err       <= 1'b0;
         resp_rdata     <= 32'h0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_byteenable <= 4'h0;
         avm_address    <= '0;
         avm_writedata  <= 32'h0;
      end else begin
         req_ready  <= (state_nxt == IDLE);
         resp_valid <= (state_nxt == RESP) || (state_nxt == ERR);
         resp_err   <= (state_nxt == ERR);
         if (accept) begin
            resp_rdata <= 32'h0;
            if (!(illegal || misalign)) begin
               avm_read       <= req_read;
               avm_write      <= req_write;
               avm_address    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
               avm_byteenable <= byte_en(req_size, req_lr, k_eff);
               avm_writedata  <= store_data(req_size, req_wdata);
            end
         end else if ((state == BUS) && !avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
         end
         if (rd_cap)
            resp_rdata <= load_result(avm_readdata, size_r, lr_r, k_r, zerox_r, rtold_r);
      end
   end

endmodule

// File: tb/tb_tiger_dmem_port.sv
// Table-driven bench for tiger_dmem_port with a cycle-accurate Avalon slave responder
// plus hand-written reset and back-to-back sequences.
module tb_tiger_dmem_port;

   logic        clk, reset;
   logic        req_valid, req_ready, req_read, req_write, req_zerox;
   logic [1:0]  req_size, req_lr;
   logic [31:0] req_addr, req_wdata, req_rtold;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
   logic [3:0]  avm_byteenable;

   int errors = 0;
   int checks = 0;

   tiger_dmem_port #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_write(req_write),
      .req_size(req_size), .req_lr(req_lr), .req_zerox(req_zerox), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rtold(req_rtold),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd, wr, zx, err;
      logic [1:0]  size, lr;
      logic [31:0] addr, wdata, rtold, mem;
      int          ws, lat;
      logic [31:0] eaddr;
      logic [3:0]  ebe;
      logic [31:0] ewd, erd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                               input logic [1:0] lr, input logic zx, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rtold,
                               input logic [31:0] mem, input int ws, input int lat,
                               input logic err, input logic [31:0] eaddr, input logic [3:0] ebe,
                               input logic [31:0] ewd, input logic [31:0] erd);
      vec_t v;
      v.rd = rd; v.wr = wr; v.size = size; v.lr = lr; v.zx = zx; v.addr = addr;
      v.wdata = wdata; v.rtold = rtold; v.mem = mem; v.ws = ws; v.lat = lat; v.err = err;
      v.eaddr = eaddr; v.ebe = ebe; v.ewd = ewd; v.erd = erd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic string nm(input int i, input string s);
      return $sformatf("v%0d_%s", i, s);
   endfunction

   task automatic idle_inputs();
      req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_size = 2'b00; req_lr = 2'b00;
      req_zerox = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rtold = 32'h0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   acc_c, rdv_c, exp_c, got_c;
      logic hold_bad, ready_bad;
      @(negedge clk);
      chk(nm(idx, "ready_in"), req_ready, 1);
      req_valid = 1'b1; req_read = v.rd; req_write = v.wr; req_size = v.size; req_lr = v.lr;
      req_zerox = v.zx; req_addr = v.addr; req_wdata = v.wdata; req_rtold = v.rtold;
      @(negedge clk);
      // request fields become don't-care once accepted
      req_valid = 1'b0; req_read = 1'($urandom); req_write = 1'($urandom);
      req_size = 2'($urandom); req_lr = 2'($urandom); req_zerox = ~v.zx;
      req_addr = $urandom; req_wdata = $urandom; req_rtold = $urandom;
      if (v.err) begin
         chk(nm(idx, "err_pulse"), {resp_valid, resp_err, avm_read, avm_write, req_ready}, 5'b11000);
         @(negedge clk);
         chk(nm(idx, "err_after"), {resp_valid, req_ready}, 2'b01);
         return;
      end
      acc_c = v.ws + 1;
      rdv_c = acc_c + v.lat;
      exp_c = v.wr ? acc_c + 1 : rdv_c + 1;
      chk(nm(idx, "addr"), avm_address, v.eaddr);
      chk(nm(idx, "be"), {28'h0, avm_byteenable}, {28'h0, v.ebe});
      if (v.wr) chk(nm(idx, "wdata"), avm_writedata, v.ewd);
      got_c = 0; hold_bad = 1'b0; ready_bad = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         if (resp_valid) begin
            got_c = c;
            break;
         end
         if (req_ready) ready_bad = 1'b1;
         if (c <= acc_c && (avm_read !== v.rd || avm_write !== v.wr ||
                            avm_address !== v.eaddr || avm_byteenable !== v.ebe))
            hold_bad = 1'b1;
         avm_waitrequest   = (c <= v.ws);
         avm_readdatavalid = v.rd && (c == rdv_c);
         avm_readdata      = (c == rdv_c) ? v.mem : 32'hDEAD_BEEF;
      end
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
      chk(nm(idx, "resp_cycle"), got_c, exp_c);
      chk(nm(idx, "rdata"), resp_rdata, v.erd);
      chk(nm(idx, "resp_flags"), {resp_err, avm_read, avm_write}, 3'b000);
      chk(nm(idx, "cmd_hold"), hold_bad, 1'b0);
      chk(nm(idx, "ready_busy"), ready_bad, 1'b0);
      @(negedge clk);
      chk(nm(idx, "after"), {resp_valid, req_ready}, 2'b01);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      //        rd wr size   lr     zx addr          wdata         rtold         mem           ws lat err eaddr         be       ewd           erd
      vecs.push_back(mk(0, 1, 2'b10, 2'b00, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 32'h0, 0, 0, 0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0));
      vecs.push_back(mk(1, 0, 2'b01, 2'b00, 0, 32'h0000_2002, 32'h0, 32'h0, 32'h80FF_1234, 2, 3, 0, 32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_80FF));
      vecs.push_back(mk(1, 0, 2'b01, 2'b00, 1, 32'h0000_2002, 32'h0, 32'h0, 32'h80FF_1234, 2, 3, 0, 32'h0000_2000, 4'b1100, 32'h0, 32'h0000_80FF));
      vecs.push_back(mk(1, 0, 2'b00, 2'b10, 0, 32'h0000_4001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, 32'h0000_4000, 4'b0011, 32'h0, 32'hCCDD_3344));
      vecs.push_back(mk(1, 0, 2'b00, 2'b01, 0, 32'h0000_4001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, 32'h0000_4000, 4'b1110, 32'h0, 32'h11AA_BBCC));
      vecs.push_back(mk(1, 0, 2'b00, 2'b10, 0, 32'h0000_4010, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 1, 0, 0, 32'h0000_4010, 4'b0001, 32'h0, 32'hDD22_3344));
      vecs.push_back(mk(1, 0, 2'b00, 2'b10, 0, 32'h0000_400B, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, 32'h0000_4008, 4'b1111, 32'h0, 32'hAABB_CCDD));
      vecs.push_back(mk(1, 0, 2'b00, 2'b01, 0, 32'h0000_4013, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 2, 0, 32'h0000_4010, 4'b1000, 32'h0, 32'h1122_33AA));
      vecs.push_back(mk(1, 0, 2'b00, 2'b01, 0, 32'h0000_400C, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, 32'h0000_400C, 4'b1111, 32'h0, 32'hAABB_CCDD));
`ifdef TIGER_DMEM_MISALIGN_TRAP_EN
      vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 32'h0000_3002, 32'h0, 32'h0, 32'h0102_0304, 0, 1, 1, 32'h0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 0, 32'h0000_6001, 32'h0000_CAFE, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0));
`else
      vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 32'h0000_3002, 32'h0, 32'h0, 32'h0102_0304, 0, 1, 0, 32'h0000_3000, 4'b1111, 32'h0, 32'h0102_0304));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 0, 32'h0000_6001, 32'h0000_CAFE, 32'h0, 32'h0, 0, 0, 0, 32'h0000_6000, 4'b0011, 32'hCAFE_CAFE, 32'h0));
`endif
      vecs.push_back(mk(1, 0, 2'b10, 2'b00, 0, 32'h0000_5001, 32'h0, 32'h0, 32'h1234_8078, 1, 0, 0, 32'h0000_5000, 4'b0010, 32'h0, 32'hFFFF_FF80));
      vecs.push_back(mk(1, 0, 2'b10, 2'b00, 1, 32'h0000_5003, 32'h0, 32'h0, 32'h9A00_0000, 0, 2, 0, 32'h0000_5000, 4'b1000, 32'h0, 32'h0000_009A));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 0, 32'h0000_6002, 32'h0000_BEEF, 32'h0, 32'h0, 1, 0, 0, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF, 32'h0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 32'h0000_7000, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 0, 32'h0000_7000, 4'b1111, 32'h1234_5678, 32'h0));
      vecs.push_back(mk(0, 0, 2'b00, 2'b00, 0, 32'h0000_7000, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk(1, 0, 2'b11, 2'b00, 0, 32'h0000_7000, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk(1, 0, 2'b00, 2'b11, 0, 32'h0000_7000, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b10, 0, 32'h0000_7001, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk(1, 1, 2'b00, 2'b00, 0, 32'h0000_7000, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0));

      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_resp", {resp_valid, resp_err}, 2'b00);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_cmd", {avm_read, avm_write, avm_byteenable}, 6'h0);
      chk("rst_addr", avm_address, 32'h0);
      chk("rst_wdata", avm_writedata, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // back-to-back LW with req_valid held high throughout
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_size = 2'b00; req_lr = 2'b00;
      req_addr = 32'h0000_8000;
      @(negedge clk);
      chk("b2b_c1", {avm_read, req_ready}, 2'b10);
      chk("b2b_addr1", avm_address, 32'h0000_8000);
      req_addr = 32'h0000_8004;
      @(negedge clk);
      chk("b2b_c2", {avm_read, req_ready, resp_valid}, 3'b000);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h1111_1111;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      chk("b2b_c3", {resp_valid, req_ready, avm_read}, 3'b100);
      chk("b2b_rd1", resp_rdata, 32'h1111_1111);
      @(negedge clk);
      chk("b2b_c4", {req_ready, avm_read, resp_valid}, 3'b100);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_c5", {avm_read, req_ready}, 2'b10);
      chk("b2b_addr2", avm_address, 32'h0000_8004);
      @(negedge clk);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h2222_2222;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      chk("b2b_c7", {resp_valid, resp_rdata}, {1'b1, 32'h2222_2222});
      @(negedge clk);
      chk("b2b_c8", {req_ready, resp_valid}, 2'b10);

      // reset while waiting for read data, with the data arriving late
      req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 32'h0000_9000;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid_c1", avm_read, 1);
      @(negedge clk);
      chk("rstmid_c2", {avm_read, resp_valid, req_ready}, 3'b000);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstmid_ready", {req_ready, resp_valid, resp_err}, 3'b100);
      chk("rstmid_cmd", {avm_read, avm_write, avm_byteenable}, 6'h0);
      chk("rstmid_addr", avm_address, 32'h0);
      chk("rstmid_wdata", avm_writedata, 32'h0);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h3333_3333;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      chk("rstmid_late1", {resp_valid, req_ready}, 2'b01);
      @(negedge clk);
      chk("rstmid_late2", {resp_valid, req_ready, avm_read}, 3'b010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
